// File: rtl/wb_uart_if.sv
// Wishbone bus bundle shared between the J1 core (master) and its slaves.
// Classic single-cycle transfers: the master holds cyc/stb/we/adr/dat_m
// until it sees ack; the slave returns ack and dat_s for exactly one cycle.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat_m;
    logic [15:0] dat_s;
    logic        ack;

    modport master (output cyc, stb, we, adr, dat_m, input ack, dat_s);
    modport slave  (input cyc, stb, we, adr, dat_m, output ack, dat_s);
endinterface

// File: rtl/wb_uart.sv
// Wishbone slave UART: DATA/STATUS/DIVISOR registers, 8N1 transmitter fed by
// a small FIFO, receiver with a single holding register and sticky flags.
module wb_uart #(
    parameter int          TX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic clk,
    input  logic reset_n,
    if_wb.slave  wb,
    input  logic uart_rxd,
    output logic uart_txd
);
    localparam int PW = $clog2(TX_DEPTH);

    // Shared by both FSMs; exposed through tx_state_q / rx_state_q.
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    logic          ack_q, ack_d;
    logic [15:0]   dat_s_q, dat_s_d;
    logic [1:0]    req_adr_q, req_adr_d;
    logic          req_we_q, req_we_d;
    logic [15:0]   req_dat_q, req_dat_d;
    logic [15:0]   div_q, div_d;
    logic [7:0]    fifo_mem_q [TX_DEPTH];
    logic [7:0]    fifo_mem_d [TX_DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          tx_drop_q, tx_drop_d;
    uart_state_e   tx_state_q, tx_state_d;
    logic [15:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;
    logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    uart_state_e   rx_state_q, rx_state_d;
    logic [15:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_overrun_q, rx_overrun_d;
    logic          rx_frame_err_q, rx_frame_err_d;

    logic          tx_full, tx_empty, tx_busy, tx_pop;
    logic          wr_data, wr_div, rd_data, rd_stat;
    logic [15:0]   status, rd_mux;
    logic          unused_adr_bits;

    assign unused_adr_bits = ^wb.adr[15:2];

    assign tx_empty = (wr_ptr_q == rd_ptr_q);
    assign tx_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign tx_busy  = (tx_state_q != S_IDLE);
    assign status   = {9'h0, tx_busy, tx_drop_q, rx_frame_err_q, rx_overrun_q,
                       rx_valid_q, tx_empty, tx_full};

    // Side effects use the request latched with ack, so they fire once in the ack cycle.
    assign wr_data = ack_q &  req_we_q & (req_adr_q == 2'd0);
    assign wr_div  = ack_q &  req_we_q & (req_adr_q == 2'd2);
    assign rd_data = ack_q & ~req_we_q & (req_adr_q == 2'd0);
    assign rd_stat = ack_q & ~req_we_q & (req_adr_q == 2'd1);

    assign wb.ack   = ack_q;
    assign wb.dat_s = dat_s_q;
    assign uart_txd = txd_q;

    // Bus handshake: one ack per request, read data captured together with ack.
    always_comb begin
        ack_d     = wb.cyc & wb.stb & ~ack_q;
        req_adr_d = ack_d ? wb.adr[1:0] : req_adr_q;
        req_we_d  = ack_d ? wb.we : req_we_q;
        req_dat_d = ack_d ? wb.dat_m : req_dat_q;
        case (wb.adr[1:0])
            2'd0:    rd_mux = {8'h0, rx_byte_q};
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = div_q;
            default: rd_mux = 16'h0;
        endcase
        dat_s_d = ack_d ? rd_mux : 16'h0;
        div_d   = div_q;
        if (wr_div) div_d = (req_dat_q < 16'd2) ? 16'd2 : req_dat_q;
    end

    // Transmitter: START, 8 data bits LSB first, STOP; chains frames without a gap.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        if (tx_state_q != S_IDLE && tx_cnt_q != 16'd0) tx_cnt_d = tx_cnt_q - 16'd1;
        case (tx_state_q)
            S_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = fifo_mem_q[rd_ptr_q[PW-1:0]];
                tx_cnt_d   = div_q - 16'd1;
                txd_d      = 1'b0;
                tx_state_d = S_START;
            end
            S_START: if (tx_cnt_q == 16'd0) begin
                tx_cnt_d   = div_q - 16'd1;
                tx_idx_d   = 3'd0;
                txd_d      = tx_shift_q[0];
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_cnt_q == 16'd0) begin
                tx_cnt_d = div_q - 16'd1;
                if (tx_idx_q == 3'd7) begin
                    txd_d      = 1'b1;
                    tx_state_d = S_STOP;
                end else begin
                    tx_idx_d   = tx_idx_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    txd_d      = tx_shift_q[1];
                end
            end
            S_STOP: if (tx_cnt_q == 16'd0) begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_mem_q[rd_ptr_q[PW-1:0]];
                    tx_cnt_d   = div_q - 16'd1;
                    txd_d      = 1'b0;
                    tx_state_d = S_START;
                end else begin
                    tx_state_d = S_IDLE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // TX FIFO: a write into a full FIFO is still accepted if the transmitter pops that cycle.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q + {{PW{1'b0}}, tx_pop};
        tx_drop_d  = tx_drop_q & ~rd_stat;
        if (wr_data) begin
            if (!tx_full || tx_pop) begin
                fifo_mem_d[wr_ptr_q[PW-1:0]] = req_dat_q[7:0];
                wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
            end else begin
                tx_drop_d = 1'b1;
            end
        end
    end

    // Receiver: synchronize, find a falling edge, sample mid-bit, judge the stop bit.
    always_comb begin
        rx_s1_d        = uart_rxd;
        rx_s2_d        = rx_s1_q;
        rx_prev_d      = rx_s2_q;
        rx_state_d     = rx_state_q;
        rx_cnt_d       = rx_cnt_q;
        rx_idx_d       = rx_idx_q;
        rx_shift_d     = rx_shift_q;
        rx_byte_d      = rx_byte_q;
        // Clears first so a flag that sets in the same cycle wins.
        rx_valid_d     = rx_valid_q & ~rd_data;
        rx_overrun_d   = rx_overrun_q & ~rd_stat;
        rx_frame_err_d = rx_frame_err_q & ~rd_stat;
        if (rx_state_q != S_IDLE && rx_cnt_q != 16'd0) rx_cnt_d = rx_cnt_q - 16'd1;
        case (rx_state_q)
            S_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_cnt_d   = {1'b0, div_q[15:1]} - 16'd1;
                rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == 16'd0) begin
                if (rx_s2_q) begin
                    rx_state_d = S_IDLE;
                end else begin
                    rx_cnt_d   = div_q - 16'd1;
                    rx_idx_d   = 3'd0;
                    rx_state_d = S_DATA;
                end
            end
            S_DATA: if (rx_cnt_q == 16'd0) begin
                rx_cnt_d   = div_q - 16'd1;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_idx_d   = rx_idx_q + 3'd1;
                if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
            end
            S_STOP: if (rx_cnt_q == 16'd0) begin
                rx_state_d = S_IDLE;
                if (!rx_s2_q) begin
                    rx_frame_err_d = 1'b1;
                end else if (rx_valid_q && !rd_data) begin
                    rx_overrun_d = 1'b1;
                end else begin
                    rx_byte_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // State register for bus, FIFO, transmitter and receiver.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q          <= 1'b0;
            dat_s_q        <= 16'h0;
            req_adr_q      <= 2'd0;
            req_we_q       <= 1'b0;
            req_dat_q      <= 16'h0;
            div_q          <= DIV_RESET;
            for (int i = 0; i < TX_DEPTH; i++) fifo_mem_q[i] <= 8'h0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            tx_drop_q      <= 1'b0;
            tx_state_q     <= S_IDLE;
            tx_cnt_q       <= 16'h0;
            tx_idx_q       <= 3'd0;
            tx_shift_q     <= 8'h0;
            txd_q          <= 1'b1;
            rx_s1_q        <= 1'b1;
            rx_s2_q        <= 1'b1;
            rx_prev_q      <= 1'b1;
            rx_state_q     <= S_IDLE;
            rx_cnt_q       <= 16'h0;
            rx_idx_q       <= 3'd0;
            rx_shift_q     <= 8'h0;
            rx_byte_q      <= 8'h0;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            ack_q          <= ack_d;
            dat_s_q        <= dat_s_d;
            req_adr_q      <= req_adr_d;
            req_we_q       <= req_we_d;
            req_dat_q      <= req_dat_d;
            div_q          <= div_d;
            fifo_mem_q     <= fifo_mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            tx_drop_q      <= tx_drop_d;
            tx_state_q     <= tx_state_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_idx_q       <= tx_idx_d;
            tx_shift_q     <= tx_shift_d;
            txd_q          <= txd_d;
            rx_s1_q        <= rx_s1_d;
            rx_s2_q        <= rx_s2_d;
            rx_prev_q      <= rx_prev_d;
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_idx_q       <= rx_idx_d;
            rx_shift_q     <= rx_shift_d;
            rx_byte_q      <= rx_byte_d;
            rx_valid_q     <= rx_valid_d;
            rx_overrun_q   <= rx_overrun_d;
            rx_frame_err_q <= rx_frame_err_d;
        end
    end
endmodule
